// File: rtl/hbram_rw_arbiter.sv
// hbram_rw_arbiter: shares the HyperRAM controller command port between the
// camera write DMA and the HDMI read DMA, one burst at a time. Round-robin
// between channels, with an urgent-read override that is capped so a pending
// write is never starved.
//
// Handshakes: a command transfers on any cycle where mem_cmd_valid_o and
// mem_cmd_ready_i are both high; while valid is high and ready is low the
// command fields hold steady. Channel requests are level requests held until
// their gnt pulse, which is high exactly on the transfer cycle.
module hbram_rw_arbiter #(
    parameter int AW         = 32,
    parameter int LW         = 8,
    parameter int MAX_CONSEC = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [LW-1:0] wr_len_i,
    output logic          wr_gnt_o,
    output logic          wr_done_o,
    input  logic          rd_req_i,
    input  logic          rd_urgent_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [LW-1:0] rd_len_i,
    output logic          rd_gnt_o,
    output logic          rd_done_o,
    output logic          mem_cmd_valid_o,
    input  logic          mem_cmd_ready_i,
    output logic          mem_cmd_we_o,
    output logic [AW-1:0] mem_cmd_addr_o,
    output logic [LW-1:0] mem_cmd_len_o,
    input  logic          mem_done_i,
    output logic          busy_o,
    output logic          owner_o,
    output logic [15:0]   wr_burst_cnt_o,
    output logic [15:0]   rd_burst_cnt_o,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CONSEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t        state;
    logic          last_wr;     // 1 = write channel was served last
    logic [CW-1:0] consec_rd;   // read grants since the last write grant, saturating
    logic          pick_wr;
    logic          accept;

    assign accept          = (state == ISSUE) && mem_cmd_ready_i;
    assign mem_cmd_valid_o = (state == ISSUE);
    assign wr_gnt_o        = accept && mem_cmd_we_o;
    assign rd_gnt_o        = accept && !mem_cmd_we_o;
    assign busy_o          = (state != IDLE);
    assign dbg_state_o     = state;

    // Winner selection for the next burst; only meaningful in IDLE.
    always_comb begin
        pick_wr = 1'b0;
        if (wr_req_i && !rd_req_i) begin
            pick_wr = 1'b1;
        end else if (wr_req_i && rd_req_i) begin
            if (rd_urgent_i && (consec_rd < MAX_C)) begin
                pick_wr = 1'b0;
            end else if (consec_rd >= MAX_C) begin
                pick_wr = 1'b1;
            end else begin
                pick_wr = !last_wr;
            end
        end
    end

    // Arbitration FSM with registered command fields, done pulses and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            last_wr        <= 1'b1;
            consec_rd      <= '0;
            mem_cmd_we_o   <= 1'b0;
            mem_cmd_addr_o <= '0;
            mem_cmd_len_o  <= '0;
            owner_o        <= 1'b0;
            wr_done_o      <= 1'b0;
            rd_done_o      <= 1'b0;
            wr_burst_cnt_o <= '0;
            rd_burst_cnt_o <= '0;
        end else begin
            wr_done_o <= 1'b0;
            rd_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req_i || rd_req_i) begin
                        mem_cmd_we_o   <= pick_wr;
                        mem_cmd_addr_o <= pick_wr ? wr_addr_i : rd_addr_i;
                        mem_cmd_len_o  <= pick_wr ? wr_len_i : rd_len_i;
                        owner_o        <= pick_wr;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready_i) begin
                        last_wr <= mem_cmd_we_o;
                        if (mem_cmd_we_o) begin
                            consec_rd <= '0;
                        end else if (consec_rd < MAX_C) begin
                            consec_rd <= consec_rd + 1'b1;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_done_i) begin
                        if (owner_o) begin
                            wr_done_o      <= 1'b1;
                            wr_burst_cnt_o <= wr_burst_cnt_o + 16'd1;
                        end else begin
                            rd_done_o      <= 1'b1;
                            rd_burst_cnt_o <= rd_burst_cnt_o + 16'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hbram_rw_arbiter.sv
// Directed testbench for hbram_rw_arbiter: single write, round-robin,
// urgent-read cap, backpressure, stray done pulses and reset mid-burst.
module tb_hbram_rw_arbiter;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int MAXC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [LW-1:0] wr_len = '0;
    logic          wr_gnt, wr_done;
    logic          rd_req = 1'b0;
    logic          rd_urgent = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [LW-1:0] rd_len = '0;
    logic          rd_gnt, rd_done;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          mem_done;
    logic          done_auto = 1'b0;
    logic          done_man = 1'b0;
    logic          busy, owner;
    logic [15:0]   wr_cnt, rd_cnt;
    logic [1:0]    dbg_state;

    assign mem_done = done_auto | done_man;

    int checks = 0;
    int errors = 0;

    // monitor state (written only by the monitor process)
    logic gq[$];
    int   gnt_n = 0;
    int   excl_viol = 0;
    int   acnt = 0;
    logic auto_en = 1'b0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    hbram_rw_arbiter #(.AW(AW), .LW(LW), .MAX_CONSEC(MAXC)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_len_i(wr_len),
        .wr_gnt_o(wr_gnt), .wr_done_o(wr_done),
        .rd_req_i(rd_req), .rd_urgent_i(rd_urgent), .rd_addr_i(rd_addr),
        .rd_len_i(rd_len), .rd_gnt_o(rd_gnt), .rd_done_o(rd_done),
        .mem_cmd_valid_o(cmd_valid), .mem_cmd_ready_i(cmd_ready),
        .mem_cmd_we_o(cmd_we), .mem_cmd_addr_o(cmd_addr), .mem_cmd_len_o(cmd_len),
        .mem_done_i(mem_done), .busy_o(busy), .owner_o(owner),
        .wr_burst_cnt_o(wr_cnt), .rd_burst_cnt_o(rd_cnt), .dbg_state_o(dbg_state)
    );

    // Grant/done monitor and auto-responding controller model (done 4 cycles after grant).
    always @(negedge clk) begin
        done_auto = 1'b0;
        if (auto_en && acnt > 0) begin
            acnt = acnt - 1;
            if (acnt == 0) done_auto = 1'b1;
        end
        if (wr_gnt || rd_gnt) begin
            if (wr_gnt && rd_gnt) excl_viol = excl_viol + 1;
            gq.push_back(wr_gnt);
            gnt_n = gnt_n + 1;
            if (auto_en) acnt = 4;
        end
        if (wr_done && rd_done) excl_viol = excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        rd_urgent = 1'b0;
        cmd_ready = 1'b0;
        done_man = 1'b0;
        auto_en = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_gnts(input int n, input int budget);
        int k;
        k = 0;
        while (gq.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check("gnt_budget", (gq.size() >= n), 1);
    endtask

    task automatic check_order(input string tag, input int base, input logic [9:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < gq.size()) check(tag, gq[base + i], exp[i]);
            else check(tag, 32'hdead, exp[i]);
        end
    endtask

    initial begin
        int base;
        int g0;
        logic [9:0] exp_rr;
        logic [9:0] exp_urg;

        // ---- reset state + single write ----
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_gnt", {wr_gnt, rd_gnt, wr_done, rd_done}, 0);
        check("rst_cmd", {cmd_we, owner, cmd_len}, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_cnt", {wr_cnt, rd_cnt}, 0);
        check("rst_state", dbg_state, 0);
        cmd_ready = 1'b1;
        cyc(); cyc();
        wr_req = 1'b1; wr_addr = 32'h0000_1000; wr_len = 8'd15;
        cyc();
        check("sw_valid", cmd_valid, 1);
        check("sw_we", cmd_we, 1);
        check("sw_addr", cmd_addr, 32'h1000);
        check("sw_len", cmd_len, 15);
        check("sw_wr_gnt", wr_gnt, 1);
        check("sw_rd_gnt", rd_gnt, 0);
        wr_req = 1'b0;
        cyc();
        check("sw_busy", {busy, owner, cmd_valid, wr_gnt}, 4'b1100);
        repeat (12) cyc();
        check("sw_no_early_done", {wr_done, wr_cnt}, 0);
        done_man = 1'b1;
        cyc();
        done_man = 1'b0;
        check("sw_wr_done", wr_done, 1);
        check("sw_rd_done", rd_done, 0);
        check("sw_wr_cnt", wr_cnt, 1);
        check("sw_idle", busy, 0);
        cyc();
        check("sw_done_pulse", wr_done, 0);

        // ---- round-robin ----
        do_reset();
        cmd_ready = 1'b1;
        auto_en = 1'b1;
        base = gq.size();
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 32'h100; rd_addr = 32'h200;
        wait_gnts(base + 4, 200);
        wr_req = 1'b0; rd_req = 1'b0;
        exp_rr = 10'b00_0000_1010;  // R,W,R,W (bit i = grant i, 1 = write)
        check_order("rr_order", base, exp_rr, 4);
        repeat (10) cyc();
        check("rr_wr_cnt", wr_cnt, 2);
        check("rr_rd_cnt", rd_cnt, 2);

        // ---- urgent cap ----
        do_reset();
        cmd_ready = 1'b1;
        auto_en = 1'b1;
        rd_urgent = 1'b1;
        base = gq.size();
        wr_req = 1'b1; rd_req = 1'b1;
        wait_gnts(base + 10, 400);
        wr_req = 1'b0; rd_req = 1'b0;
        exp_urg = 10'b10_0001_0000;  // R,R,R,R,W,R,R,R,R,W
        check_order("urg_order", base, exp_urg, 10);
        repeat (10) cyc();
        rd_urgent = 1'b0;
        auto_en = 1'b0;
        check("urg_rd_cnt", rd_cnt, 8);
        check("urg_wr_cnt", wr_cnt, 2);

        // ---- backpressure ----
        do_reset();
        g0 = gnt_n;
        wr_req = 1'b1; wr_addr = 32'hA5A5_0040; wr_len = 8'd7;
        cyc();
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", cmd_valid, 1);
            check("bp_addr", cmd_addr, 32'hA5A5_0040);
            check("bp_len", cmd_len, 7);
            check("bp_no_gnt", {wr_gnt, rd_gnt}, 0);
            if (i < 6) cyc();
        end
        cmd_ready = 1'b1;
        #1;
        check("bp_gnt", wr_gnt, 1);
        cyc();
        wr_req = 1'b0;
        check("bp_busy", {busy, cmd_valid, wr_gnt}, 3'b100);
        check("bp_gnt_count", gnt_n - g0, 1);
        done_man = 1'b1;
        cyc();
        done_man = 1'b0;
        check("bp_done", {wr_done, wr_cnt}, {1'b1, 16'd1});

        // ---- stray done in IDLE and ISSUE ----
        cyc();
        done_man = 1'b1;
        cyc();
        done_man = 1'b0;
        check("sd_idle", {wr_done, rd_done, busy}, 0);
        check("sd_idle_cnt", {wr_cnt, rd_cnt}, {16'd1, 16'd0});
        cmd_ready = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h2000; rd_len = 8'd3;
        cyc();
        done_man = 1'b1;
        cyc();
        done_man = 1'b0;
        check("sd_issue_valid", {cmd_valid, owner, cmd_we}, 3'b100);
        check("sd_issue_done", {wr_done, rd_done}, 0);
        check("sd_issue_cnt", {wr_cnt, rd_cnt}, {16'd1, 16'd0});
        cmd_ready = 1'b1;
        #1;
        check("sd_rd_gnt", {rd_gnt, wr_gnt}, 2'b10);
        cyc();
        rd_req = 1'b0;

        // ---- reset in BUSY ----
        cyc();
        check("rb_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rb_idle", {busy, cmd_valid, owner, cmd_we}, 0);
        check("rb_pulses", {wr_gnt, rd_gnt, wr_done, rd_done}, 0);
        check("rb_cnt", {wr_cnt, rd_cnt}, 0);
        check("rb_cmd", {cmd_addr, cmd_len}, 0);
        cyc();
        check("rb_no_done", rd_done, 0);
        wr_req = 1'b1; wr_addr = 32'h3000; wr_len = 8'd0;
        cyc();
        check("rb_wr_issue", {cmd_valid, cmd_we, wr_gnt}, 3'b111);
        check("rb_wr_addr", cmd_addr, 32'h3000);
        wr_req = 1'b0;
        cyc();
        done_man = 1'b1;
        cyc();
        done_man = 1'b0;
        check("rb_wr_done", {wr_done, rd_done}, 2'b10);
        check("rb_wr_cnt", {wr_cnt, rd_cnt}, {16'd1, 16'd0});

        check("pulse_exclusive", excl_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
